// File: rtl/switch_sweep_checker.sv
// Exhaustive sweep of a small combinational block: drives every switch vector,
// samples the response after a hold window and compares it with a reference table.
module switch_sweep_checker #(
    parameter int N_IN        = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [2**N_IN-1:0]    expected,
    input  logic                  s,
    output logic [N_IN-1:0]       sw,
    output logic                  busy,
    output logic                  done,
    output logic [2**N_IN-1:0]    table_out,
    output logic                  mismatch,
    output logic [N_IN:0]         fail_count,
    output logic                  dbg_state
);

    localparam int T     = 2**N_IN;
    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]  VEC_LAST  = N_IN'(T - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_IN-1:0]    r_sw;
    logic [T-1:0]       r_expected;
    logic [T-1:0]       r_table;
    logic [N_IN:0]      r_fail;
    logic               r_busy;
    logic               r_done;
    logic               r_mismatch;

    logic               w_sample;
    logic               w_last;
    logic [T-1:0]       w_table_new;

    // Abort suppresses the sample, so a partial table never gains the aborted entry.
    assign w_sample = (r_state == S_RUN) && !abort && (r_cnt == HOLD_LAST);
    assign w_last   = w_sample && (r_sw == VEC_LAST);

    always_comb begin
        w_table_new       = r_table;
        w_table_new[r_sw] = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_RUN;
            S_RUN: begin
                if (abort || w_last) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_sw       <= '0;
            r_expected <= '0;
            r_table    <= '0;
            r_fail     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_expected <= expected;
                    r_table    <= '0;
                    r_fail     <= '0;
                    r_mismatch <= 1'b0;
                    r_sw       <= '0;
                    r_cnt      <= '0;
                    r_busy     <= 1'b1;
                end
            end else if (abort) begin
                r_busy <= 1'b0;
                r_sw   <= '0;
                r_cnt  <= '0;
            end else if (w_sample) begin
                r_table <= w_table_new;
                if (s != r_expected[r_sw]) r_fail <= r_fail + 1'b1;
                r_cnt <= '0;
                if (w_last) begin
                    // Compare against the table including this final sample.
                    r_sw       <= '0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_mismatch <= (w_table_new != r_expected);
                end else begin
                    r_sw <= r_sw + 1'b1;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sw         = r_sw;
    assign busy       = r_busy;
    assign done       = r_done;
    assign table_out  = r_table;
    assign mismatch   = r_mismatch;
    assign fail_count = r_fail;
    assign dbg_state  = (r_state == S_RUN);

endmodule

// File: tb/tb_switch_sweep_checker.sv
// Directed bench for switch_sweep_checker: full sweeps, mismatches, abort,
// asynchronous reset mid-sweep and back-to-back sweeps with a one-cycle hold.
module tb_switch_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, stuck;
    logic [15:0] expected;
    logic        s;
    logic [3:0]  sw;
    logic        busy, done, mismatch, dbg_state;
    logic [15:0] table_out;
    logic [4:0]  fail_count;

    logic        start2;
    logic        abort2 = 1'b0;
    logic [15:0] expected2;
    logic        s2;
    logic [3:0]  sw2;
    logic        busy2, done2, mismatch2, dbg_state2;
    logic [15:0] table_out2;
    logic [4:0]  fail_count2;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    // Block under test: s = (A & B) | (C & D), truth table 16'hF888.
    assign s  = stuck ? 1'b0 : ((sw[3] & sw[2]) | (sw[1] & sw[0]));
    assign s2 = (sw2[3] & sw2[2]) | (sw2[1] & sw2[0]);

    switch_sweep_checker #(.N_IN(4), .HOLD_CYCLES(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected(expected), .s(s), .sw(sw), .busy(busy), .done(done),
        .table_out(table_out), .mismatch(mismatch), .fail_count(fail_count),
        .dbg_state(dbg_state)
    );

    switch_sweep_checker #(.N_IN(4), .HOLD_CYCLES(1)) u_dut_h1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .expected(expected2), .s(s2), .sw(sw2), .busy(busy2), .done(done2),
        .table_out(table_out2), .mismatch(mismatch2), .fail_count(fail_count2),
        .dbg_state(dbg_state2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep, then follow it edge by edge until done (bounded).
    task automatic run_sweep(input logic [15:0] exp_tab, output int done_at, output int walk_err);
        done_at  = -1;
        walk_err = 0;
        expected = exp_tab;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        expected = ~exp_tab;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (done) begin
                done_at = c;
                break;
            end
            if (sw !== 4'(c / 4) || busy !== 1'b1) walk_err++;
        end
    endtask

    initial begin
        int done_at, walk_err, done_seen, first_done, second_done;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stuck = 1'b0;
        expected = 16'h0; start2 = 1'b0; expected2 = 16'hF888;
        repeat (3) tick();
        check("rst_sw", 32'(sw), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_table", 32'(table_out), 0);
        check("rst_mismatch", 32'(mismatch), 0);
        check("rst_fail", 32'(fail_count), 0);
        rst_n = 1'b1;
        tick();

        // Matching reference table.
        run_sweep(16'hF888, done_at, walk_err);
        check("t1_latency", 32'(done_at), 64);
        check("t1_sw_walk", 32'(walk_err), 0);
        check("t1_table", 32'(table_out), 32'hF888);
        check("t1_mismatch", 32'(mismatch), 0);
        check("t1_fail", 32'(fail_count), 0);
        check("t1_busy", 32'(busy), 0);
        tick();
        check("t1_done_drop", 32'(done), 0);

        // One wrong entry in the reference.
        run_sweep(16'hF889, done_at, walk_err);
        check("t2_latency", 32'(done_at), 64);
        check("t2_table", 32'(table_out), 32'hF888);
        check("t2_mismatch", 32'(mismatch), 1);
        check("t2_fail", 32'(fail_count), 1);
        tick();

        // Response stuck low.
        stuck = 1'b1;
        run_sweep(16'hF888, done_at, walk_err);
        stuck = 1'b0;
        check("t3_table", 32'(table_out), 0);
        check("t3_fail", 32'(fail_count), 7);
        check("t3_mismatch", 32'(mismatch), 1);
        tick();

        // Abort on edge 20, with a stray start on edge 10.
        expected = 16'hF888;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_dbg_run", 32'(dbg_state), 1);
        repeat (8) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_start_ignored_sw", 32'(sw), 2);
        repeat (9) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_busy", 32'(busy), 0);
        check("t4_abort_sw", 32'(sw), 0);
        check("t4_abort_done", 32'(done), 0);
        check("t4_abort_table", 32'(table_out), 32'h0008);
        check("t4_abort_fail", 32'(fail_count), 0);
        check("t4_abort_mismatch", 32'(mismatch), 0);
        done_seen = 0;
        for (int c = 0; c < 70; c++) begin
            tick();
            if (done || busy) done_seen++;
        end
        check("t4_no_done_after_abort", 32'(done_seen), 0);

        // Asynchronous reset 30 edges into a sweep.
        stuck = 1'b1;
        expected = 16'hF888;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        rst_n = 1'b0;
        #2;
        check("t5_rst_sw", 32'(sw), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_table", 32'(table_out), 0);
        check("t5_rst_fail", 32'(fail_count), 0);
        check("t5_rst_mismatch", 32'(mismatch), 0);
        stuck = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t5_idle_after_rst", 32'(busy), 0);
        run_sweep(16'hF888, done_at, walk_err);
        check("t5_latency", 32'(done_at), 64);
        check("t5_sw_walk", 32'(walk_err), 0);
        check("t5_table", 32'(table_out), 32'hF888);
        check("t5_mismatch", 32'(mismatch), 0);
        tick();

        // One-cycle hold, start held through the first done cycle.
        start2 = 1'b1;
        tick();
        done_seen = 0; first_done = -1; second_done = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 17) start2 = 1'b0;
            if (done2) begin
                done_seen++;
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
            if (c == 17) check("t6_restart_busy", 32'(busy2), 1);
        end
        check("t6_first_done", 32'(first_done), 16);
        check("t6_second_done", 32'(second_done), 33);
        check("t6_done_count", 32'(done_seen), 2);
        check("t6_table", 32'(table_out2), 32'hF888);
        check("t6_mismatch", 32'(mismatch2), 0);
        check("t6_fail", 32'(fail_count2), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
